getir_hizalayici: RTL and testbench
===================================

GETIR_HIZALAYICI -- requirements
Module: getir_hizalayici

Interface
REQ-001 SHALL have parameter OBEK_BIT, default 64: L1B fetch block width; legal values 32, 64, 128.
REQ-002 SHALL have parameter DERINLIK, default 16: halfword queue depth; power of 2, at least 2*OBEK_BIT/16.
REQ-003 SHALL have parameter MAKS_ISTEK, default 8: maximum outstanding L1B requests.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk_i and rst_i.
REQ-005 clk_i  in  1  clock.
REQ-006 rst_i  in  1  synchronous active-high reset.
REQ-007 g1_istek_yapildi_i  in  1  getir1 issued an L1B request this cycle.
REQ-008 g1_istek_izin_o  out  1  getir1 may issue a request this cycle.
REQ-009 l1b_obek_i  in  OBEK_BIT  fetch block, halfword 0 in bits [15:0].
REQ-010 l1b_ps_i  in  PS_BIT  fetch PC of the block; the low bits give the first useful halfword.
REQ-011 l1b_gecerli_i / l1b_hazir_o  in / out  1  block handshake.
REQ-012 coz_buyruk_o  out  32  instruction; RVC is zero-extended.
REQ-013 coz_ps_o  out  PS_BIT  instruction PC.
REQ-014 coz_rvc_o  out  1  compressed instruction.
REQ-015 coz_gecerli_o / coz_hazir_i  out / in  1  decode handshake.
REQ-016 bosalt_i  in  1  flush (redirect).
REQ-017 doluluk_o  out  $clog2(DERINLIK)+1  halfwords held in the queue.

Function
REQ-018 Acceptance SHALL occur when l1b_gecerli_i && l1b_hazir_o.
- Halfwords from index ps[log2(OBEK_BIT/8)-1:1] to the top of the block are pushed in order.
- Lower halfwords are dropped.
REQ-019 If the queue is empty (after pops) at acceptance, head PC SHALL be set to l1b_ps_i with bit 0 cleared; otherwise blocks are treated as contiguous (not checked).
REQ-020 The head instruction SHALL be complete as follows:
- head[1:0] != 2'b11: RVC, 1 halfword.
- otherwise: 32-bit, 2 halfwords.
- coz_gecerli_o = complete && !bosalt_i.
REQ-021 coz_buyruk_o, coz_ps_o and coz_rvc_o SHALL be driven only from queue storage and the head-PC register, with no combinational path from l1b_* inputs; a block accepted at edge N yields its first instruction no earlier than cycle N+1.
REQ-022 On a pop handshake, the head SHALL advance 1 or 2 halfwords and head PC SHALL advance by 2 or 4, modulo 2^PS_BIT.
REQ-023 With coz_hazir_i low, all coz_* outputs SHALL hold stable.
REQ-024 A 32-bit instruction split across blocks SHALL wait with valid low until its upper halfword arrives.
REQ-025 An instruction split across the queue wrap (index DERINLIK-1 and index 0) SHALL be assembled correctly.
REQ-026 Push and pop in the same cycle SHALL both take effect.
REQ-027 doluluk_o SHALL equal pushed minus popped halfwords.
REQ-028 l1b_hazir_o SHALL be 1 when either:
- free slots (after this cycle's pop) >= OBEK_BIT/16; or
- the drop counter is nonzero.
REQ-029 The outstanding counter SHALL update each cycle by +1 on g1_istek_yapildi_i and -1 on non-dropped acceptance.
REQ-030 g1_istek_izin_o SHALL be 1 only when both hold:
- outstanding < MAKS_ISTEK;
- doluluk_o + (outstanding+1)*OBEK_BIT/16 <= DERINLIK.
REQ-031 On bosalt_i, the following SHALL happen next cycle:
- queue empty;
- outstanding = g1_istek_yapildi_i ? 1 : 0;
- drop counter += old outstanding minus any acceptance in the flush cycle.
- Any push or pop in the flush cycle is void.
REQ-032 While the drop counter is nonzero, accepted blocks SHALL be discarded, each decrementing the drop counter; no queue change occurs.
REQ-033 A flush arriving while dropping SHALL accumulate into the drop counter.
REQ-034 The drop counter SHALL be sized for MAKS_ISTEK*2.

Reset
REQ-035 While rst_i is high, the following SHALL be 0 on the next edge, including mid-transfer:
- queue pointers, doluluk_o, outstanding counter, drop counter, head PC;
- coz_gecerli_o, coz_buyruk_o, coz_ps_o, coz_rvc_o.
REQ-036 After reset, l1b_hazir_o = 1 and g1_istek_izin_o = 1.

Structure
REQ-037 PS_BIT and BUYRUK_BIT SHALL come from the shared sabitler.vh; RVC-detect and halfword-width constants SHALL be added there.
REQ-038 Storage SHALL be a sub-module yarim_kuyruk: a circular halfword queue with variable-count push (up to OBEK_BIT/16), exposing head and head+1 halfwords, and a pop of 0/1/2.

Verification (OBEK_BIT=64, DERINLIK=16)
REQ-039 Aligned 32-bit: block 0x00000013_00000013 at ps 0x1000 -> two outputs, ps 0x1000 and 0x1004, rvc=0, in consecutive cycles.
REQ-040 Unaligned start: ps 0x1006, halfword 3 = 0x4501 -> single output 0x00004501, ps 0x1006, rvc=1.
REQ-041 Block-straddle:
- Block at 0x1000 with halfwords 0x0001, 0x0001, 0x0001, 0x0013 -> three RVC outputs.
- Valid stays low until the next block (halfword 0 = 0x0000) arrives.
- Then 0x00000013 at ps 0x1006.
REQ-042 Flush and drop:
- 3 requests issued, then bosalt_i.
- The 3 stale responses are accepted with no output.
- The following block at ps 0x2000 is emitted, ps 0x2000.
REQ-043 Backpressure and wrap:
- coz_hazir_i low for 20 cycles -> g1_istek_izin_o drops at the credit limit.
- On release, all instructions emerge in order, including a 32-bit instruction straddling index 15/0.
REQ-044 rst_i pulsed with a half-assembled instruction and 2 requests outstanding -> all outputs 0; the next block at ps 0x3000 is emitted normally.

Source files
------------

// File: rtl/getir_hizalayici_pkg.sv
// Shared constants for the fetch aligner: PC/instruction widths, halfword width
// and the RVC length-decode rule.
package getir_hizalayici_pkg;

    localparam int PS_BIT     = 32;
    localparam int BUYRUK_BIT = 32;
    localparam int YARIM_BIT  = 16;

    // Low two bits of the first halfword equal to 2'b11 mark a full 32-bit instruction.
    localparam logic [1:0] RVC_DEGIL = 2'b11;

    function automatic logic rvc_mi(input logic [1:0] alt_bitler);
        return alt_bitler != RVC_DEGIL;
    endfunction

endpackage

// File: rtl/getir_hizalayici_yarim_kuyruk.sv
// Circular halfword queue: pushes up to GIRIS halfwords per cycle, pops 0/1/2,
// exposes the head halfword and the one after it.
module yarim_kuyruk
    import getir_hizalayici_pkg::*;
#(
    parameter int DERINLIK = 16,
    parameter int GIRIS    = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          temizle_i,
    input  logic [$clog2(GIRIS):0]        itme_sayi_i,
    input  logic [GIRIS*YARIM_BIT-1:0]    itme_veri_i,
    input  logic [1:0]                    cekme_sayi_i,
    output logic [YARIM_BIT-1:0]          bas_o,
    output logic [YARIM_BIT-1:0]          bas1_o,
    output logic [$clog2(DERINLIK):0]     doluluk_o
);

    localparam int AW = $clog2(DERINLIK);
    localparam int DW = AW + 1;
    localparam int SW = $clog2(GIRIS) + 1;

    logic [YARIM_BIT-1:0] mem_q [DERINLIK];
    logic [AW-1:0]        bas_q, bas_d, kuyruk_q, kuyruk_d, bas1_adr;
    logic [DW-1:0]        doluluk_q, doluluk_d;
    logic [AW-1:0]        yaz_adr [GIRIS];
    logic [GIRIS-1:0]     yaz_en;

    // Halfword gi of the (pre-shifted) block lands gi slots past the tail.
    generate
        for (genvar gi = 0; gi < GIRIS; gi++) begin : g_yaz
            assign yaz_adr[gi] = kuyruk_q + AW'(gi);
            assign yaz_en[gi]  = !temizle_i && (itme_sayi_i > SW'(gi));
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < GIRIS; i++) begin
            if (yaz_en[i]) begin
                mem_q[yaz_adr[i]] <= itme_veri_i[i*YARIM_BIT +: YARIM_BIT];
            end
        end
    end

    always_comb begin
        bas_d     = bas_q + AW'(cekme_sayi_i);
        kuyruk_d  = kuyruk_q + AW'(itme_sayi_i);
        doluluk_d = doluluk_q + DW'(itme_sayi_i) - DW'(cekme_sayi_i);
        if (temizle_i) begin
            bas_d     = '0;
            kuyruk_d  = '0;
            doluluk_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bas_q     <= '0;
            kuyruk_q  <= '0;
            doluluk_q <= '0;
        end else begin
            bas_q     <= bas_d;
            kuyruk_q  <= kuyruk_d;
            doluluk_q <= doluluk_d;
        end
    end

    assign bas1_adr  = bas_q + AW'(1);
    assign bas_o     = mem_q[bas_q];
    assign bas1_o    = mem_q[bas1_adr];
    assign doluluk_o = doluluk_q;

endmodule

// File: rtl/getir_hizalayici.sv
// Fetch aligner: turns L1I fetch blocks into a stream of 16/32-bit instructions,
// with request credit control and flush-time discarding of stale responses.
module getir_hizalayici
    import getir_hizalayici_pkg::*;
#(
    parameter int OBEK_BIT   = 64,
    parameter int DERINLIK   = 16,
    parameter int MAKS_ISTEK = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        g1_istek_yapildi_i,
    output logic                        g1_istek_izin_o,
    input  logic [OBEK_BIT-1:0]         l1b_obek_i,
    input  logic [PS_BIT-1:0]           l1b_ps_i,
    input  logic                        l1b_gecerli_i,
    output logic                        l1b_hazir_o,
    output logic [BUYRUK_BIT-1:0]       coz_buyruk_o,
    output logic [PS_BIT-1:0]           coz_ps_o,
    output logic                        coz_rvc_o,
    output logic                        coz_gecerli_o,
    input  logic                        coz_hazir_i,
    input  logic                        bosalt_i,
    output logic [$clog2(DERINLIK):0]   doluluk_o
);

    localparam int GIRIS = OBEK_BIT / YARIM_BIT;
    localparam int IW    = $clog2(GIRIS);
    localparam int OW    = $clog2(OBEK_BIT / 8);
    localparam int SW    = IW + 1;
    localparam int DW    = $clog2(DERINLIK) + 1;
    localparam int BW    = $clog2(MAKS_ISTEK + 1);
    localparam int KW    = $clog2(2 * MAKS_ISTEK + 1);

    logic [IW-1:0]        ilk_idx;
    logic [OBEK_BIT-1:0]  itme_veri;
    logic [SW-1:0]        itme_sayi;
    logic [1:0]           cekme_sayi;
    logic [YARIM_BIT-1:0] bas, bas1;
    logic [DW-1:0]        doluluk;
    logic                 kabul, itme, cekme, dusuruluyor, bas_rvc, tamam;
    logic [BW-1:0]        bekleyen_q, bekleyen_d;
    logic [KW-1:0]        dusur_q, dusur_d, dusur_toplam;
    logic [PS_BIT-1:0]    bas_ps_q, bas_ps_d;

    yarim_kuyruk #(
        .DERINLIK (DERINLIK),
        .GIRIS    (GIRIS)
    ) u_kuyruk (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .temizle_i    (bosalt_i),
        .itme_sayi_i  (itme_sayi),
        .itme_veri_i  (itme_veri),
        .cekme_sayi_i (cekme_sayi),
        .bas_o        (bas),
        .bas1_o       (bas1),
        .doluluk_o    (doluluk)
    );

    // Drop the halfwords below the fetch PC by shifting the block down.
    assign ilk_idx   = l1b_ps_i[OW-1:1];
    assign itme_veri = l1b_obek_i >> {ilk_idx, 4'b0000};

    assign dusuruluyor   = dusur_q != '0;
    assign bas_rvc       = rvc_mi(bas[1:0]);
    assign tamam         = bas_rvc ? (doluluk != '0) : (doluluk >= DW'(2));
    assign coz_gecerli_o = tamam && !bosalt_i;
    assign cekme         = coz_gecerli_o && coz_hazir_i;
    assign cekme_sayi    = !cekme ? 2'd0 : (bas_rvc ? 2'd1 : 2'd2);

    assign l1b_hazir_o = ((DERINLIK - int'(doluluk) + int'(cekme_sayi)) >= GIRIS) || dusuruluyor;
    assign kabul       = l1b_gecerli_i && l1b_hazir_o;
    assign itme        = kabul && !dusuruluyor && !bosalt_i;
    assign itme_sayi   = itme ? SW'(GIRIS - int'(ilk_idx)) : '0;

    // Credit: reserve a whole block of space for every request still in flight.
    assign g1_istek_izin_o = (int'(bekleyen_q) < MAKS_ISTEK) &&
                             ((int'(doluluk) + (int'(bekleyen_q) + 1) * GIRIS) <= DERINLIK);

    assign dusur_toplam = dusur_q + KW'(bekleyen_q);

    always_comb begin
        bekleyen_d = bekleyen_q;
        dusur_d    = dusur_q;
        if (bosalt_i) begin
            bekleyen_d = g1_istek_yapildi_i ? BW'(1) : '0;
            dusur_d    = (kabul && dusur_toplam != '0) ? dusur_toplam - KW'(1) : dusur_toplam;
        end else begin
            if (g1_istek_yapildi_i) begin
                bekleyen_d = bekleyen_d + BW'(1);
            end
            if (kabul && !dusuruluyor && bekleyen_d != '0) begin
                bekleyen_d = bekleyen_d - BW'(1);
            end
            if (kabul && dusuruluyor) begin
                dusur_d = dusur_q - KW'(1);
            end
        end
    end

    // A block landing in a queue that drains empty this cycle re-seeds the head PC.
    always_comb begin
        bas_ps_d = bas_ps_q;
        if (itme && doluluk == DW'(cekme_sayi)) begin
            bas_ps_d = l1b_ps_i & ~PS_BIT'(1);
        end else if (cekme) begin
            bas_ps_d = bas_ps_q + (bas_rvc ? PS_BIT'(2) : PS_BIT'(4));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bekleyen_q <= '0;
            dusur_q    <= '0;
            bas_ps_q   <= '0;
        end else begin
            bekleyen_q <= bekleyen_d;
            dusur_q    <= dusur_d;
            bas_ps_q   <= bas_ps_d;
        end
    end

    assign coz_buyruk_o = !tamam ? '0 :
                          (bas_rvc ? {{(BUYRUK_BIT-YARIM_BIT){1'b0}}, bas} : {bas1, bas});
    assign coz_ps_o     = bas_ps_q;
    assign coz_rvc_o    = tamam && bas_rvc;
    assign doluluk_o    = doluluk;

endmodule

// File: tb/tb_getir_hizalayici.sv
// Directed bench for the fetch aligner: table of single-block vectors plus
// hand sequences for straddle, flush/drop, backpressure/wrap and mid-run reset.
module tb_getir_hizalayici;

    logic        clk_i;
    logic        rst_i;
    logic        g1_istek_yapildi_i;
    logic        g1_istek_izin_o;
    logic [63:0] l1b_obek_i;
    logic [31:0] l1b_ps_i;
    logic        l1b_gecerli_i;
    logic        l1b_hazir_o;
    logic [31:0] coz_buyruk_o;
    logic [31:0] coz_ps_o;
    logic        coz_rvc_o;
    logic        coz_gecerli_o;
    logic        coz_hazir_i;
    logic        bosalt_i;
    logic [4:0]  doluluk_o;

    getir_hizalayici #(
        .OBEK_BIT   (64),
        .DERINLIK   (16),
        .MAKS_ISTEK (8)
    ) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .g1_istek_yapildi_i (g1_istek_yapildi_i),
        .g1_istek_izin_o    (g1_istek_izin_o),
        .l1b_obek_i         (l1b_obek_i),
        .l1b_ps_i           (l1b_ps_i),
        .l1b_gecerli_i      (l1b_gecerli_i),
        .l1b_hazir_o        (l1b_hazir_o),
        .coz_buyruk_o       (coz_buyruk_o),
        .coz_ps_o           (coz_ps_o),
        .coz_rvc_o          (coz_rvc_o),
        .coz_gecerli_o      (coz_gecerli_o),
        .coz_hazir_i        (coz_hazir_i),
        .bosalt_i           (bosalt_i),
        .doluluk_o          (doluluk_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        yeni;
        logic [63:0] obek;
        logic [31:0] ps;
        logic [31:0] buy;
        logic [31:0] pc;
        logic        rvc;
    } vek_t;

    vek_t        tablo [10];
    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] got_b [$];
    logic [31:0] got_p [$];
    logic        got_r [$];

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    task automatic clear_got();
        got_b.delete();
        got_p.delete();
        got_r.delete();
    endtask

    task automatic collect(input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            if (coz_gecerli_o) begin
                got_b.push_back(coz_buyruk_o);
                got_p.push_back(coz_ps_o);
                got_r.push_back(coz_rvc_o);
            end
            tick();
        end
    endtask

    task automatic cmp_next(input string nm, input logic [31:0] b, input logic [31:0] p,
                            input logic r);
        logic [31:0] gb, gp;
        logic        gr;
        if (got_b.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: no output, expected buyruk %h ps %h", nm, b, p);
        end else begin
            gb = got_b.pop_front();
            gp = got_p.pop_front();
            gr = got_r.pop_front();
            $display("%s: buyruk=%h ps=%h rvc=%0d", nm, gb, gp, gr);
            chk({nm, "_buyruk"}, gb, b);
            chk({nm, "_ps"}, gp, p);
            chk({nm, "_rvc"}, 32'(gr), 32'(r));
        end
    endtask

    task automatic send_block(input logic [63:0] ob, input logic [31:0] ps, input logic req);
        int n;
        n = 0;
        l1b_gecerli_i      = 1'b1;
        l1b_obek_i         = ob;
        l1b_ps_i           = ps;
        g1_istek_yapildi_i = req;
        #1;
        while (!l1b_hazir_o && n < 50) begin
            tick();
            g1_istek_yapildi_i = 1'b0;
            n++;
        end
        if (n >= 50) begin
            n_vec++;
            n_bad++;
            $display("FAIL l1b_timeout: hazir stayed 0, expected 1 within 50 cycles (ps %h)", ps);
        end
        tick();
        l1b_gecerli_i      = 1'b0;
        g1_istek_yapildi_i = 1'b0;
    endtask

    task automatic reset_pulse();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
    endtask

    initial begin
        int st;
        logic acc;

        tablo[0] = '{1'b1, 64'h0000_0013_0000_0013, 32'h1000, 32'h0000_0013, 32'h1000, 1'b0};
        tablo[1] = '{1'b0, 64'h0,                   32'h0,    32'h0000_0013, 32'h1004, 1'b0};
        tablo[2] = '{1'b1, 64'h4501_0000_0000_0000, 32'h1006, 32'h0000_4501, 32'h1006, 1'b1};
        tablo[3] = '{1'b1, 64'h0001_0002_4505_0001, 32'h2000, 32'h0000_0001, 32'h2000, 1'b1};
        tablo[4] = '{1'b0, 64'h0,                   32'h0,    32'h0000_4505, 32'h2002, 1'b1};
        tablo[5] = '{1'b0, 64'h0,                   32'h0,    32'h0000_0002, 32'h2004, 1'b1};
        tablo[6] = '{1'b0, 64'h0,                   32'h0,    32'h0000_0001, 32'h2006, 1'b1};
        tablo[7] = '{1'b1, 64'h1234_0093_0001_FFFF, 32'h3002, 32'h0000_0001, 32'h3002, 1'b1};
        tablo[8] = '{1'b0, 64'h0,                   32'h0,    32'h1234_0093, 32'h3004, 1'b0};
        tablo[9] = '{1'b1, 64'hC0D0_A0B3_AAAA_5555, 32'h4004, 32'hC0D0_A0B3, 32'h4004, 1'b0};

        rst_i = 1'b1;
        g1_istek_yapildi_i = 1'b0;
        l1b_obek_i = '0;
        l1b_ps_i = '0;
        l1b_gecerli_i = 1'b0;
        coz_hazir_i = 1'b1;
        bosalt_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b0;

        chk("rst_gecerli", 32'(coz_gecerli_o), 0);
        chk("rst_buyruk", coz_buyruk_o, 0);
        chk("rst_ps", coz_ps_o, 0);
        chk("rst_rvc", 32'(coz_rvc_o), 0);
        chk("rst_doluluk", 32'(doluluk_o), 0);
        chk("rst_l1b_hazir", 32'(l1b_hazir_o), 1);
        chk("rst_izin", 32'(g1_istek_izin_o), 1);

        // Table vectors: each new block is sent, its outputs collected, then matched in order.
        for (int i = 0; i < 10; i++) begin
            if (tablo[i].yeni) begin
                if (i > 0) chk($sformatf("vec%0d_extra_outputs", i), 32'(got_b.size()), 0);
                clear_got();
                send_block(tablo[i].obek, tablo[i].ps, 1'b1);
                collect(6);
            end
            cmp_next($sformatf("vec%0d", i), tablo[i].buy, tablo[i].pc, tablo[i].rvc);
        end
        chk("vec_tail_extra_outputs", 32'(got_b.size()), 0);

        // Block straddle: the trailing 32-bit half waits for the next block.
        clear_got();
        send_block(64'h0013_0001_0001_0001, 32'h1000, 1'b1);
        collect(6);
        chk("straddle_wait_valid", 32'(coz_gecerli_o), 0);
        chk("straddle_wait_doluluk", 32'(doluluk_o), 1);
        send_block(64'h0001_0001_0001_0000, 32'h1008, 1'b1);
        collect(8);
        cmp_next("straddle0", 32'h0000_0001, 32'h1000, 1'b1);
        cmp_next("straddle1", 32'h0000_0001, 32'h1002, 1'b1);
        cmp_next("straddle2", 32'h0000_0001, 32'h1004, 1'b1);
        cmp_next("straddle3", 32'h0000_0013, 32'h1006, 1'b0);
        cmp_next("straddle4", 32'h0000_0001, 32'h100A, 1'b1);
        cmp_next("straddle5", 32'h0000_0001, 32'h100C, 1'b1);
        cmp_next("straddle6", 32'h0000_0001, 32'h100E, 1'b1);
        chk("straddle_extra_outputs", 32'(got_b.size()), 0);

        // Flush with three requests in flight: their responses must vanish.
        clear_got();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("flush_izin%0d", k), 32'(g1_istek_izin_o), 1);
            g1_istek_yapildi_i = 1'b1;
            tick();
        end
        g1_istek_yapildi_i = 1'b0;
        bosalt_i = 1'b1;
        tick();
        bosalt_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            send_block(64'h0001_0001_0001_0001, 32'h7000, 1'b0);
            chk($sformatf("stale%0d_valid", k), 32'(coz_gecerli_o), 0);
            chk($sformatf("stale%0d_doluluk", k), 32'(doluluk_o), 0);
        end
        send_block(64'h0000_0013_0000_0013, 32'h2000, 1'b1);
        collect(6);
        cmp_next("flush_out0", 32'h0000_0013, 32'h2000, 1'b0);
        cmp_next("flush_out1", 32'h0000_0013, 32'h2004, 1'b0);
        chk("flush_extra_outputs", 32'(got_b.size()), 0);

        // Backpressure: decode stalls 20 cycles, credit runs out, then drain across the wrap.
        reset_pulse();
        clear_got();
        coz_hazir_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("bp_izin%0d", k), 32'(g1_istek_izin_o), 1);
            g1_istek_yapildi_i = 1'b1;
            tick();
        end
        g1_istek_yapildi_i = 1'b0;
        chk("bp_izin_credit_limit", 32'(g1_istek_izin_o), 0);
        send_block(64'h0009_0005_0001_FFFF, 32'h5002, 1'b0);
        send_block(64'h1111_2223_3333_4443, 32'h5008, 1'b0);
        send_block(64'h5555_6667_7777_8887, 32'h5010, 1'b0);
        send_block(64'h9999_AAAB_BBBB_CCCF, 32'h5018, 1'b0);
        chk("bp_doluluk", 32'(doluluk_o), 15);
        chk("bp_l1b_hazir_full", 32'(l1b_hazir_o), 0);
        chk("bp_izin_full", 32'(g1_istek_izin_o), 0);
        repeat (12) tick();
        chk("bp_hold_valid", 32'(coz_gecerli_o), 1);
        chk("bp_hold_buyruk", coz_buyruk_o, 32'h0000_0001);
        chk("bp_hold_ps", coz_ps_o, 32'h5002);
        chk("bp_hold_rvc", 32'(coz_rvc_o), 1);
        coz_hazir_i = 1'b1;
        l1b_obek_i = 64'h0001_0001_DEAD_BEE3;
        l1b_ps_i = 32'h5020;
        st = 0;
        for (int c = 0; c < 40; c++) begin
            g1_istek_yapildi_i = (st == 0) && g1_istek_izin_o;
            l1b_gecerli_i = (st == 1);
            #1;
            if (coz_gecerli_o) begin
                got_b.push_back(coz_buyruk_o);
                got_p.push_back(coz_ps_o);
                got_r.push_back(coz_rvc_o);
            end
            acc = l1b_gecerli_i && l1b_hazir_o;
            tick();
            if (st == 0 && g1_istek_yapildi_i) st = 1;
            else if (st == 1 && acc) st = 2;
        end
        g1_istek_yapildi_i = 1'b0;
        l1b_gecerli_i = 1'b0;
        chk("bp_block_e_accepted", 32'(st), 2);
        cmp_next("bp0", 32'h0000_0001, 32'h5002, 1'b1);
        cmp_next("bp1", 32'h0000_0005, 32'h5004, 1'b1);
        cmp_next("bp2", 32'h0000_0009, 32'h5006, 1'b1);
        cmp_next("bp3", 32'h3333_4443, 32'h5008, 1'b0);
        cmp_next("bp4", 32'h1111_2223, 32'h500C, 1'b0);
        cmp_next("bp5", 32'h7777_8887, 32'h5010, 1'b0);
        cmp_next("bp6", 32'h5555_6667, 32'h5014, 1'b0);
        cmp_next("bp7", 32'hBBBB_CCCF, 32'h5018, 1'b0);
        cmp_next("bp8", 32'h9999_AAAB, 32'h501C, 1'b0);
        cmp_next("bp9_wrap", 32'hDEAD_BEE3, 32'h5020, 1'b0);
        cmp_next("bp10", 32'h0000_0001, 32'h5024, 1'b1);
        cmp_next("bp11", 32'h0000_0001, 32'h5026, 1'b1);
        chk("bp_extra_outputs", 32'(got_b.size()), 0);

        // Reset with a half-assembled instruction and two requests outstanding.
        clear_got();
        send_block(64'h0013_0001_0001_0001, 32'h6000, 1'b1);
        collect(6);
        chk("mid_rst_pre_doluluk", 32'(doluluk_o), 1);
        g1_istek_yapildi_i = 1'b1;
        tick();
        tick();
        g1_istek_yapildi_i = 1'b0;
        reset_pulse();
        chk("mid_rst_gecerli", 32'(coz_gecerli_o), 0);
        chk("mid_rst_buyruk", coz_buyruk_o, 0);
        chk("mid_rst_ps", coz_ps_o, 0);
        chk("mid_rst_rvc", 32'(coz_rvc_o), 0);
        chk("mid_rst_doluluk", 32'(doluluk_o), 0);
        chk("mid_rst_l1b_hazir", 32'(l1b_hazir_o), 1);
        chk("mid_rst_izin", 32'(g1_istek_izin_o), 1);
        clear_got();
        send_block(64'h0000_0013_0000_0013, 32'h3000, 1'b1);
        collect(6);
        cmp_next("post_rst0", 32'h0000_0013, 32'h3000, 1'b0);
        cmp_next("post_rst1", 32'h0000_0013, 32'h3004, 1'b0);
        chk("post_rst_extra_outputs", 32'(got_b.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
